// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the hazard/branch/memory logic and the
// pipeline stall controller. The master side drives the hazard, branch and
// memory handshake flags. The slave side (the controller) drives the
// freeze, bubble and flush controls, the state and the performance counters.
// Handshake semantics: mem_req marks a load/store that occupies MEM in this
// cycle, and mem_ready marks the cycle in which memory completes it. The
// stage stalls on every cycle with mem_req=1 and mem_ready=0. The
// branch_taken flag is a single-cycle pulse from EXE.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 hazard_detected;
    logic                 branch_taken;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 pc_freeze;
    logic                 if_id_freeze;
    logic                 if_id_flush;
    logic                 id_exe_bubble;
    logic                 exe_mem_freeze;
    logic                 mem_wb_bubble;
    logic [1:0]           ctrl_state;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] mem_wait_cnt;
    logic                 timeout_err;

    modport master (
        output hazard_detected, branch_taken, mem_req, mem_ready,
        input  pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
               exe_mem_freeze, mem_wb_bubble, ctrl_state,
               stall_cnt, flush_cnt, mem_wait_cnt, timeout_err
    );

    modport slave (
        input  hazard_detected, branch_taken, mem_req, mem_ready,
        output pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
               exe_mem_freeze, mem_wb_bubble, ctrl_state,
               stall_cnt, flush_cnt, mem_wait_cnt, timeout_err
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// It produces the freeze, bubble and flush controls combinationally from
// the FSM state and the current inputs. A multi-cycle memory access freezes
// the whole pipeline. A branch that is taken in the first stalled cycle is
// held back and issued as a flush when memory releases.
// Optional macro STALL_PERF_CNT_EN builds the stall, flush and mem-wait
// performance counters. Without it, those counter outputs are tied to 0.
module pipeline_stall_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } state_t;

    localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);

    // FLUSH_PEND is itself the pending-flush flag: it is set only by a branch
    // that coincides with the first stall cycle, and it is cleared on release.
    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_timeout_err;

    state_t               w_state_nxt;
    logic                 w_mem_stall;
    logic                 w_wait_state;
    logic                 w_pc_freeze;
    logic                 w_if_id_freeze;
    logic                 w_if_id_flush;
    logic                 w_id_exe_bubble;
    logic                 w_exe_mem_freeze;
    logic                 w_mem_wb_bubble;

    assign w_mem_stall  = bus.mem_req & ~bus.mem_ready;
    assign w_wait_state = (r_state == ST_MEM_WAIT) || (r_state == ST_FLUSH_PEND);

    // Next state and same-cycle pipeline controls; everything is quiet in reset
    always_comb begin
        w_state_nxt      = ST_RUN;
        w_pc_freeze      = 1'b0;
        w_if_id_freeze   = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_exe_bubble  = 1'b0;
        w_exe_mem_freeze = 1'b0;
        w_mem_wb_bubble  = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        w_pc_freeze      = 1'b1;
                        w_if_id_freeze   = 1'b1;
                        w_exe_mem_freeze = 1'b1;
                        w_mem_wb_bubble  = 1'b1;
                        // EXE is already frozen in MEM_WAIT, so a branch there is stale
                        if (r_state == ST_RUN && bus.branch_taken)
                            w_state_nxt = ST_FLUSH_PEND;
                        else
                            w_state_nxt = ST_MEM_WAIT;
                    end else if (bus.branch_taken) begin
                        w_if_id_flush   = 1'b1;
                        w_id_exe_bubble = 1'b1;
                    end else if (bus.hazard_detected) begin
                        w_pc_freeze     = 1'b1;
                        w_if_id_freeze  = 1'b1;
                        w_id_exe_bubble = 1'b1;
                    end
                end
                ST_FLUSH_PEND: begin
                    if (w_mem_stall) begin
                        w_pc_freeze      = 1'b1;
                        w_if_id_freeze   = 1'b1;
                        w_exe_mem_freeze = 1'b1;
                        w_mem_wb_bubble  = 1'b1;
                        w_state_nxt      = ST_FLUSH_PEND;
                    end else begin
                        // Deferred flush wins; any hazard this cycle is discarded
                        w_if_id_flush   = 1'b1;
                        w_id_exe_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state, consecutive-wait timer and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wait_state) begin
                if (r_timer != TIMER_W'(MEM_TIMEOUT))
                    r_timer <= r_timer + TIMER_W'(1);
                if (r_timer >= TIMER_W'(MEM_TIMEOUT - 1))
                    r_timeout_err <= 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic [CNT_WIDTH-1:0] r_mem_wait_cnt;

    // Saturating performance counters; a hazard stall is the only case with both pc_freeze and a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
            r_mem_wait_cnt <= '0;
        end else begin
            if (w_pc_freeze && w_id_exe_bubble && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_if_id_flush && (r_flush_cnt != {CNT_WIDTH{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_wait_state && (r_mem_wait_cnt != {CNT_WIDTH{1'b1}}))
                r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
    assign bus.mem_wait_cnt = r_mem_wait_cnt;
`else
    assign bus.stall_cnt    = {CNT_WIDTH{1'b0}};
    assign bus.flush_cnt    = {CNT_WIDTH{1'b0}};
    assign bus.mem_wait_cnt = {CNT_WIDTH{1'b0}};
`endif

    assign bus.pc_freeze      = w_pc_freeze;
    assign bus.if_id_freeze   = w_if_id_freeze;
    assign bus.if_id_flush    = w_if_id_flush;
    assign bus.id_exe_bubble  = w_id_exe_bubble;
    assign bus.exe_mem_freeze = w_exe_mem_freeze;
    assign bus.mem_wb_bubble  = w_mem_wb_bubble;
    assign bus.ctrl_state     = r_state;
    assign bus.timeout_err    = r_timeout_err;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (CNT_WIDTH=3, MEM_TIMEOUT=4).
// A rule-level model is checked against every output on every cycle. The
// directed scenarios also carry hand-computed literal expectations.
module tb_pipeline_stall_ctrl;
  localparam int CW = 3;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_stall_ctrl_if #(.CNT_WIDTH(CW)) bus();

  pipeline_stall_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int perf(input int v);
    return PERF ? v : 0;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit m_waiting = 0;   // pipeline was frozen by memory on the previous cycle
  bit m_owed    = 0;   // a taken branch is waiting for memory to release
  bit m_timeout = 0;
  int m_run     = 0;   // consecutive cycles spent waiting
  int m_stall   = 0;
  int m_flush   = 0;
  int m_wait    = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(negedge clk) begin
    bit stall, f_frz, f_flush, f_haz;
    int e_state;
    stall   = bus.mem_req && !bus.mem_ready;
    f_frz   = 0;
    f_flush = 0;
    f_haz   = 0;
    if (!rst) begin
      if (stall)                           f_frz   = 1;
      else if (m_owed || bus.branch_taken) f_flush = 1;
      else if (bus.hazard_detected)        f_haz   = 1;
    end
    e_state = !m_waiting ? 0 : (m_owed ? 2 : 1);

    check("cmp_pc_freeze",      bus.pc_freeze,      32'(f_frz | f_haz));
    check("cmp_if_id_freeze",   bus.if_id_freeze,   32'(f_frz | f_haz));
    check("cmp_if_id_flush",    bus.if_id_flush,    32'(f_flush));
    check("cmp_id_exe_bubble",  bus.id_exe_bubble,  32'(f_flush | f_haz));
    check("cmp_exe_mem_freeze", bus.exe_mem_freeze, 32'(f_frz));
    check("cmp_mem_wb_bubble",  bus.mem_wb_bubble,  32'(f_frz));
    check("cmp_ctrl_state",     bus.ctrl_state,     32'(e_state));
    check("cmp_stall_cnt",      bus.stall_cnt,      32'(perf(m_stall)));
    check("cmp_flush_cnt",      bus.flush_cnt,      32'(perf(m_flush)));
    check("cmp_mem_wait_cnt",   bus.mem_wait_cnt,   32'(perf(m_wait)));
    check("cmp_timeout_err",    bus.timeout_err,    32'(m_timeout));

    if (rst) begin
      m_waiting = 0; m_owed = 0; m_timeout = 0; m_run = 0;
      m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      if (m_waiting) begin
        m_wait = sat(m_wait + 1);
        m_run++;
        if (m_run >= TO) m_timeout = 1;
      end else begin
        m_run = 0;
      end
      if (f_haz)   m_stall = sat(m_stall + 1);
      if (f_flush) m_flush = sat(m_flush + 1);
      m_owed    = stall && (m_owed || (!m_waiting && bus.branch_taken));
      m_waiting = stall;
    end
  end

  // ---------------- driver tasks ----------------
  // One pipeline cycle: drive after the rising edge, return after the falling edge
  task automatic cyc(input bit h, input bit b, input bit rq, input bit rd);
    @(posedge clk); #1;
    rst                 = 1'b0;
    bus.hazard_detected = h;
    bus.branch_taken    = b;
    bus.mem_req         = rq;
    bus.mem_ready       = rd;
    @(negedge clk); #1;
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst                 = 1'b1;
      bus.hazard_detected = 1'b1;
      bus.branch_taken    = 1'b1;
      bus.mem_req         = 1'b1;
      bus.mem_ready       = 1'b1;
      @(negedge clk); #1;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst                 = 1'b1;
    bus.hazard_detected = 1'b1;
    bus.branch_taken    = 1'b1;
    bus.mem_req         = 1'b1;
    bus.mem_ready       = 1'b1;

    // Reset with every input high: everything quiet
    for (int i = 0; i < 2; i++) begin
      rst_cycles(1);
      check("rst_pc_freeze",   bus.pc_freeze,     0);
      check("rst_if_id_flush", bus.if_id_flush,   0);
      check("rst_bubble",      bus.id_exe_bubble, 0);
      check("rst_exe_freeze",  bus.exe_mem_freeze, 0);
      check("rst_state",       bus.ctrl_state,    0);
      check("rst_stall_cnt",   bus.stall_cnt,     0);
      check("rst_timeout",     bus.timeout_err,   0);
    end

    // Load-use hazard
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("lu_pc_freeze", bus.pc_freeze,     1);
    check("lu_ifid_frz",  bus.if_id_freeze,  1);
    check("lu_bubble",    bus.id_exe_bubble, 1);
    check("lu_flush",     bus.if_id_flush,   0);
    cyc(0, 0, 0, 0);
    check("lu_stall_cnt", bus.stall_cnt, 32'(perf(1)));

    // Branch over hazard
    rst_cycles(1);
    cyc(1, 1, 0, 0);
    check("bh_flush",     bus.if_id_flush,   1);
    check("bh_bubble",    bus.id_exe_bubble, 1);
    check("bh_pc_freeze", bus.pc_freeze,     0);
    cyc(0, 0, 0, 0);
    check("bh_flush_cnt", bus.flush_cnt, 32'(perf(1)));
    check("bh_stall_cnt", bus.stall_cnt, 0);

    // Memory wait: 3 stall cycles then ready
    rst_cycles(1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      check("mw_exe_freeze", bus.exe_mem_freeze, 1);
      check("mw_state",      bus.ctrl_state,     (i == 0) ? 0 : 1);
    end
    cyc(0, 0, 1, 1);
    check("mw_rel_freeze", bus.exe_mem_freeze, 0);
    check("mw_rel_state",  bus.ctrl_state,     1);
    cyc(0, 0, 0, 0);
    check("mw_run_state",  bus.ctrl_state,   0);
    check("mw_wait_cnt",   bus.mem_wait_cnt, 32'(perf(3)));
    check("mw_no_timeout", bus.timeout_err,  0);

    // Deferred flush: branch in first stall cycle, release after 2 stall cycles
    rst_cycles(1);
    cyc(0, 1, 1, 0);
    check("df_c1_flush", bus.if_id_flush, 0);
    check("df_c1_frz",   bus.pc_freeze,   1);
    cyc(0, 0, 1, 0);
    check("df_c2_state", bus.ctrl_state,  2);
    check("df_c2_flush", bus.if_id_flush, 0);
    cyc(1, 0, 1, 1);
    check("df_rel_state",  bus.ctrl_state,    2);
    check("df_rel_flush",  bus.if_id_flush,   1);
    check("df_rel_bubble", bus.id_exe_bubble, 1);
    check("df_rel_pcfrz",  bus.pc_freeze,     0);
    cyc(0, 0, 0, 0);
    check("df_after_flush", bus.if_id_flush, 0);
    check("df_flush_cnt",   bus.flush_cnt,   32'(perf(1)));
    check("df_stall_cnt",   bus.stall_cnt,   0);

    // Branch while already in MEM_WAIT is ignored
    rst_cycles(1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    check("ig_state", bus.ctrl_state,  1);
    check("ig_flush", bus.if_id_flush, 0);
    cyc(0, 0, 1, 1);
    check("ig_rel_flush", bus.if_id_flush, 0);
    cyc(0, 0, 0, 0);
    check("ig_flush_cnt", bus.flush_cnt, 0);

    // Branch on the MEM_WAIT release cycle follows the normal run rules
    rst_cycles(1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    check("rb_flush", bus.if_id_flush, 1);
    cyc(0, 0, 0, 0);
    check("rb_flush_cnt", bus.flush_cnt, 32'(perf(1)));

    // Counter saturation: 10 hazard cycles into a 3-bit counter
    rst_cycles(1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("sat_stall_cnt", bus.stall_cnt, 32'(perf(CMAX)));

    // Timeout: 6 stall cycles with MEM_TIMEOUT=4
    rst_cycles(1);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 1, 0);
      check("to_timeout", bus.timeout_err, (i == 6) ? 1 : 0);
    end
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    check("to_sticky", bus.timeout_err, 1);
    check("to_state",  bus.ctrl_state,  0);
    cyc(0, 0, 0, 0);
    check("to_sticky2", bus.timeout_err, 1);

    // Reset mid-wait drops the pending flush and clears the timeout
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    check("rmw_state", bus.ctrl_state, 2);
    rst_cycles(1);
    cyc(0, 0, 0, 0);
    check("rmw_state_run", bus.ctrl_state,  0);
    check("rmw_no_flush",  bus.if_id_flush, 0);
    check("rmw_timeout",   bus.timeout_err, 0);

    // Random-free tail: a few mixed cycles scored by the model only
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 1);
    cyc(0, 0, 0, 0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
